reg_scoreboard: RTL

// - Register-hazard scheduler between decode and execute. Tracks the in-flight writes to

---
 rtl/reg_scoreboard_pkg.sv | 15 +
 rtl/reg_scoreboard_entry.sv | 41 ++++
 rtl/reg_scoreboard.sv | 110 +++++++++++
 3 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared types and constants for the register scoreboard.
// - REG_SEL_W : width of a register select (rs1/rs2/rd/wb_rd)
// - NUM_REGS  : architectural register count
// - DEF_CNT_W : default per-register in-flight counter width
// - cnt_t     : counter type at the default width
// - REG_ZERO  : the hardwired-zero register, never tracked
package scoreboard_types;
    localparam int REG_SEL_W = 5;
    localparam int NUM_REGS  = 32;
    localparam int DEF_CNT_W = 2;

    typedef logic [DEF_CNT_W-1:0] cnt_t;

    localparam logic [REG_SEL_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/reg_scoreboard_entry.sv
// One register's saturating in-flight write counter.
// Ports:
// - clk, rst  : clock, synchronous active-high reset
// - inc       : an issue targets this register
// - dec       : a writeback retires a write to this register
// - clr       : flush; clears the counter and overrides inc/dec
// - cnt       : current count
// - busy      : cnt != 0
// - sat       : cnt == max; further issues must stall
// - underflow : dec alone with cnt == 0 (counter stays at 0)
module scoreboard_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             sat,
    output logic             underflow
);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            if (cnt != MAX) cnt <= cnt + ONE;
        end else if (dec && !inc) begin
            if (cnt != '0) cnt <= cnt - ONE;
        end
    end

    assign busy      = (cnt != '0);
    assign sat       = (cnt == MAX);
    // A simultaneous inc cancels the dec, so it is not an underflow.
    assign underflow = dec && !inc && !clr && (cnt == '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Register-hazard scheduler between decode and execute. Counts in-flight
// writes per architectural register and tells decode whether to stall.
// Ports:
// - clk, rst                    : clock, synchronous active-high reset
// - flush                       : clears all counters, drops same-cycle issue/wb
// - chk_rs1/_used, chk_rs2/_used: decode source selects and read enables
// - chk_rd, chk_rd_write        : decode destination and write enable
// - hazard                      : comb stall request for the decode instruction
// - issue                       : instruction accepted by execute
// - wb_valid, wb_rd             : writeback retiring one write
// - busy_mask                   : bit i = counter[i] != 0, bit 0 always 0
// - inflight_total              : registered sum of all counters
// - sb_error                    : sticky underflow / issue-under-hazard flag
module reg_scoreboard
    import scoreboard_types::*;
#(
    parameter int NUM_REGS  = scoreboard_types::NUM_REGS,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WB_BYPASS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [REG_SEL_W-1:0] chk_rs1,
    input  logic                 chk_rs1_used,
    input  logic [REG_SEL_W-1:0] chk_rs2,
    input  logic                 chk_rs2_used,
    input  logic [REG_SEL_W-1:0] chk_rd,
    input  logic                 chk_rd_write,
    output logic                 hazard,
    input  logic                 issue,
    input  logic                 wb_valid,
    input  logic [REG_SEL_W-1:0] wb_rd,
    output logic [NUM_REGS-1:0]  busy_mask,
    output logic [7:0]           inflight_total,
    output logic                 sb_error
);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0]            inc, dec, busy, sat, underflow;
    logic [NUM_REGS-1:0]            up, dn;

    // x0 is never tracked: its slot is tied off.
    assign cnt[0]       = '0;
    assign busy[0]      = 1'b0;
    assign sat[0]       = 1'b0;
    assign underflow[0] = 1'b0;
    assign inc[0]       = 1'b0;
    assign dec[0]       = 1'b0;
    assign up[0]        = 1'b0;
    assign dn[0]        = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        assign inc[r] = issue && chk_rd_write && (chk_rd == REG_SEL_W'(r));
        assign dec[r] = wb_valid && (wb_rd == REG_SEL_W'(r));
        // Effective count moves, used to track the total without an adder tree.
        assign up[r]  = inc[r] && !dec[r] && !sat[r];
        assign dn[r]  = dec[r] && !inc[r] && busy[r];

        scoreboard_entry #(.CNT_W(CNT_W)) u_ent (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc[r]),
            .dec       (dec[r]),
            .clr       (flush),
            .cnt       (cnt[r]),
            .busy      (busy[r]),
            .sat       (sat[r]),
            .underflow (underflow[r])
        );
    end

    assign busy_mask = busy;

    // A source is not pending if the write it waits on retires this cycle
    // and is the last one outstanding.
    logic pend1, pend2, rd_full;
    always_comb begin
        pend1 = busy[chk_rs1];
        pend2 = busy[chk_rs2];
        if (WB_BYPASS != 0 && wb_valid) begin
            if (wb_rd == chk_rs1 && cnt[chk_rs1] == ONE) pend1 = 1'b0;
            if (wb_rd == chk_rs2 && cnt[chk_rs2] == ONE) pend2 = 1'b0;
        end
        rd_full = chk_rd_write && (chk_rd != REG_ZERO) && sat[chk_rd];
        hazard  = (chk_rs1_used && pend1) || (chk_rs2_used && pend2) || rd_full;
    end

    // At most one register moves up and one moves down per cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inflight_total <= '0;
        end else begin
            unique case ({|up, |dn})
                2'b10:   inflight_total <= inflight_total + 8'd1;
                2'b01:   inflight_total <= inflight_total - 8'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_error <= 1'b0;
        end else if (!flush && ((|underflow) || (issue && hazard))) begin
            sb_error <= 1'b1;
        end
    end
endmodule
